// File: rtl/neuron_out_serializer.sv
// Purpose: latch a bank of signed neuron outputs, stream them one word per cycle, track the signed argmax.
// Latency: out_valid with word0 one cycle after an accepted load; done pulses one cycle after the final transfer.
// Backpressure: out_ready=0 freezes out_data/out_idx/out_last/out_valid; a frame may stall indefinitely.
module neuron_out_serializer #(
  parameter int DWIDTH = 16,
  parameter int NWORDS = 10,
  parameter int IDXW   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [NWORDS*DWIDTH-1:0] data_in,
  output logic                     load_ready,
  output logic signed [DWIDTH-1:0] out_data,
  output logic [IDXW-1:0]          out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     done,
  output logic [IDXW-1:0]          max_idx,
  output logic signed [DWIDTH-1:0] max_val
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Captured frame; never rewritten while a frame is being sent.
  logic signed [DWIDTH-1:0] bank [NWORDS];

  // Running argmax of the words presented so far in the current frame.
  logic signed [DWIDTH-1:0] run_max_val;
  logic [IDXW-1:0]          run_max_idx;

  logic                     do_load;
  logic                     do_xfer;
  logic                     last_xfer;
  logic [IDXW-1:0]          nxt_idx;
  logic signed [DWIDTH-1:0] nxt_word;

  // load_ready decodes the state register directly, so it is high in the done cycle.
  assign load_ready = (state == IDLE);
  assign nxt_idx    = out_idx + IDXW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and datapath strobes; out_ready only reaches registers, never an output.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_xfer   = 1'b0;
    last_xfer = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          do_load   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_valid && out_ready) begin
          do_xfer = 1'b1;
          if (out_idx == LAST_IDX) begin
            last_xfer = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the bank word that follows the one currently presented.
  always_comb begin
    nxt_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (nxt_idx == IDXW'(i)) begin
        nxt_word = bank[i];
      end
    end
  end

  // Bank capture on an accepted load only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) begin
        bank[i] <= '0;
      end
    end else if (do_load) begin
      for (int i = 0; i < NWORDS; i++) begin
        bank[i] <= data_in[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Output stream, running argmax and frame result; ties keep the earlier index (strict compare).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_idx     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      max_idx     <= '0;
      max_val     <= '0;
      run_max_idx <= '0;
      run_max_val <= '0;
    end else begin
      done <= 1'b0;
      if (do_load) begin
        out_data    <= data_in[DWIDTH-1:0];
        out_idx     <= '0;
        out_valid   <= 1'b1;
        out_last    <= (NWORDS == 1);
        run_max_val <= data_in[DWIDTH-1:0];
        run_max_idx <= '0;
      end else if (last_xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
        max_idx   <= run_max_idx;
        max_val   <= run_max_val;
      end else if (do_xfer) begin
        out_data <= nxt_word;
        out_idx  <= nxt_idx;
        out_last <= (nxt_idx == LAST_IDX);
        if (nxt_word > run_max_val) begin
          run_max_val <= nxt_word;
          run_max_idx <= nxt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_out_serializer.sv
module tb_neuron_out_serializer;

  localparam int DW = 16;
  localparam int NW = 10;
  localparam int IW = 4;

  typedef int words_t [NW];

  typedef struct {
    words_t w;
    int     mi;
    int     mv;
    int     mode;
  } vec_t;

  typedef struct {
    int idx;
    int data;
    bit last;
  } ent_t;

  typedef struct {
    int idx;
    int val;
  } mx_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load;
  logic [NW*DW-1:0]   data_in;
  logic               load_ready;
  logic signed [DW-1:0] out_data;
  logic [IW-1:0]      out_idx;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               done;
  logic [IW-1:0]      max_idx;
  logic signed [DW-1:0] max_val;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   done_cyc [$];
  ent_t sb [$];
  mx_t  maxq [$];
  bit   pend_done = 1'b0;
  vec_t vt [6];

  neuron_out_serializer #(
    .DWIDTH(DW),
    .NWORDS(NW),
    .IDXW  (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data_in   (data_in),
    .load_ready(load_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done),
    .max_idx   (max_idx),
    .max_val   (max_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NW*DW-1:0] pack(input words_t w);
    logic [NW*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[i*DW +: DW] = DW'(w[i]);
    return r;
  endfunction

  function automatic mx_t ref_max(input words_t w);
    mx_t m;
    m.idx = 0;
    m.val = w[0];
    for (int i = 1; i < NW; i++) begin
      if (w[i] > m.val) begin
        m.idx = i;
        m.val = w[i];
      end
    end
    return m;
  endfunction

  task automatic push_frame(input words_t w, input int mi, input int mv);
    ent_t e;
    mx_t  m;
    for (int i = 0; i < NW; i++) begin
      e.idx  = i;
      e.data = w[i];
      e.last = (i == NW - 1);
      sb.push_back(e);
    end
    m.idx = mi;
    m.val = mv;
    maxq.push_back(m);
  endtask

  task automatic do_load(input words_t w);
    @(posedge clk); #1;
    chk("load_ready_idle", int'(load_ready), 1);
    data_in = pack(w);
    load    = 1'b1;
    @(posedge clk); #1;
    load    = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int mode);
    bit reached;
    reached = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (done_cnt >= target) begin
        reached = 1'b1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
    end
    if (!reached) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    ent_t e;
    mx_t  m;
    if (!rst_n) begin
      pend_done = 1'b0;
    end else begin
      chk("done_pulse", int'(done), int'(pend_done));
      if (done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        chk("valid_at_done", int'(out_valid), 0);
        chk("load_ready_at_done", int'(load_ready), 1);
        if (maxq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL max_unexpected: got done with max_idx %0d, expected no done", max_idx);
        end else begin
          m = maxq.pop_front();
          chk("max_idx", int'(max_idx), m.idx);
          chk("max_val", int'(max_val), m.val);
        end
      end
      pend_done = 1'b0;
      if (out_valid) begin
        chk("load_ready_busy", int'(load_ready), 0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_word: got idx %0d data %0d, expected no valid", out_idx, out_data);
        end else begin
          e = sb[0];
          chk("word_idx", int'(out_idx), e.idx);
          chk("word_data", int'(out_data), e.data);
          chk("word_last", int'(out_last), int'(e.last));
          if (out_ready) begin
            void'(sb.pop_front());
            pend_done = e.last;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    words_t wb;
    mx_t    mb;
    int     start;
    int     n;

    vt[0].w = '{5, -3, 100, 7, 100, -32768, 32767, 0, 1, 2};
    vt[0].mi = 6; vt[0].mv = 32767; vt[0].mode = 0;
    vt[1].w = '{5, -3, 100, 7, 100, -32768, 32767, 0, 1, 2};
    vt[1].mi = 6; vt[1].mv = 32767; vt[1].mode = 1;
    vt[2].w = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    vt[2].mi = 0; vt[2].mv = -1; vt[2].mode = 2;
    vt[3].w = '{-5, -2, -9, -7, -3, -4, -8, -6, -10, -11};
    vt[3].mi = 1; vt[3].mv = -2; vt[3].mode = 0;
    vt[4].w = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 9};
    vt[4].mi = 9; vt[4].mv = 9; vt[4].mode = 1;
    vt[5].w = '{32767, 0, -1, 5, 32767, -32768, 12, 32767, 1, 0};
    vt[5].mi = 0; vt[5].mv = 32767; vt[5].mode = 2;

    rst_n     = 1'b0;
    load      = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    #12;
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_max_idx", int'(max_idx), 0);
    chk("rst_max_val", int'(max_val), 0);
    chk("rst_load_ready", int'(load_ready), 1);
    #11;
    rst_n = 1'b1;

    // Table-driven frames with different backpressure patterns.
    for (int v = 0; v < 6; v++) begin
      start = done_cnt;
      push_frame(vt[v].w, vt[v].mi, vt[v].mv);
      do_load(vt[v].w);
      wait_dones(start + 1, vt[v].mode);
    end

    // Load held through SEND and the final transfer with other data; it lands on the done cycle.
    for (int i = 0; i < NW; i++) wb[i] = int'($urandom_range(0, 65535)) - 32768;
    mb = ref_max(wb);
    start = done_cnt;
    push_frame(vt[0].w, vt[0].mi, vt[0].mv);
    push_frame(wb, mb.idx, mb.val);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("load_ready_pre_hold", int'(load_ready), 1);
    data_in = pack(vt[0].w);
    load    = 1'b1;
    @(posedge clk); #1;
    data_in = pack(wb);
    repeat (NW + 1) @(posedge clk);
    #1;
    load = 1'b0;
    wait_dones(start + 2, 0);
    n = done_cyc.size();
    if (n >= 2) chk("load_on_done_spacing", done_cyc[n-1] - done_cyc[n-2], NW + 1);

    // Asynchronous reset in the middle of a frame.
    push_frame(vt[5].w, vt[5].mi, vt[5].mv);
    out_ready = 1'b1;
    do_load(vt[5].w);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_reset_idx", int'(out_idx), 4);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_idx", int'(out_idx), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_out_last", int'(out_last), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_load_ready", int'(load_ready), 1);
    chk("arst_max_val", int'(max_val), 0);
    sb.delete();
    maxq.delete();
    start = done_cnt;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_load_ready", int'(load_ready), 1);
    chk("post_reset_no_done", done_cnt, start);

    // Back-to-back frames with load held continuously.
    start = done_cnt;
    push_frame(vt[3].w, vt[3].mi, vt[3].mv);
    push_frame(vt[2].w, vt[2].mi, vt[2].mv);
    push_frame(vt[0].w, vt[0].mi, vt[0].mv);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("load_ready_b2b", int'(load_ready), 1);
    data_in = pack(vt[3].w);
    load    = 1'b1;
    @(posedge clk); #1;
    data_in = pack(vt[2].w);
    repeat (NW + 1) @(posedge clk);
    #1;
    data_in = pack(vt[0].w);
    repeat (NW + 1) @(posedge clk);
    #1;
    load = 1'b0;
    wait_dones(start + 3, 0);
    n = done_cyc.size();
    if (n >= 3) begin
      chk("b2b_spacing_1", done_cyc[n-2] - done_cyc[n-3], NW + 1);
      chk("b2b_spacing_2", done_cyc[n-1] - done_cyc[n-2], NW + 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("maxq_drained", maxq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
